// File: rtl/mux_arb_ctrl_4ch.sv
// mux_arb_ctrl_4ch: four-channel packet multiplexer arbiter.
// Round-robin grant of one channel's FIFO to the shared output; a grant ends on
// that channel's EOP or on watchdog timeout, followed by a fixed idle gap.
module mux_arb_ctrl_4ch #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        arb_en,
  input  logic [3:0]  pkt_rdy,
  input  logic [3:0]  pkt_eop,
  output logic [3:0]  fifo_ren,
  output logic        grant_vld,
  output logic [1:0]  grant_id,
  output logic        timeout_err,
  output logic [15:0] pkt_total_cnt
);

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GRANT = 3'b010,
    ST_GAP   = 3'b100
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  last_id;
  logic [15:0] wdog;
  logic [3:0]  gap_cnt;
  logic        armed;
  logic [1:0]  cand;
  logic [1:0]  win_id;
  logic        win_found;
  logic        eop_hit;
  logic        wdog_hit;

  // Round-robin winner search starting just after the last owner, with wrap
  always_comb begin
    win_found = 1'b0;
    win_id    = last_id;
    cand      = last_id;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_id + 2'(k);
      if (!win_found && pkt_rdy[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Grant termination conditions; only the owning channel's EOP counts
  always_comb begin
    eop_hit  = pkt_eop[grant_id];
    wdog_hit = (wdog == WDOG_LAST);
  end

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; illegal encodings fall back to idle.
  // armed holds off arbitration for the first edge after reset release.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (armed && arb_en && win_found) state_nxt = ST_GRANT;
      ST_GRANT: if (eop_hit || wdog_hit)          state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST)          state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs derived from the registered state and owner
  always_comb begin
    grant_vld = (state == ST_GRANT);
    fifo_ren  = grant_vld ? (4'b0001 << grant_id) : '0;
  end

  // Owner, watchdog, gap timer, packet counter and timeout pulse
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      armed         <= 1'b0;
      grant_id      <= '0;
      last_id       <= 2'd3;
      wdog          <= '0;
      gap_cnt       <= '0;
      pkt_total_cnt <= '0;
      timeout_err   <= 1'b0;
    end else begin
      armed       <= 1'b1;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_GRANT) begin
            grant_id <= win_id;
            wdog     <= '0;
          end
        end
        ST_GRANT: begin
          wdog    <= wdog + 16'd1;
          gap_cnt <= '0;
          if (eop_hit) begin
            pkt_total_cnt <= pkt_total_cnt + 16'd1;
            last_id       <= grant_id;
          end else if (wdog_hit) begin
            timeout_err <= 1'b1;
            last_id     <= grant_id;
          end
        end
        ST_GAP: gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arb_ctrl_4ch.sv
// Testbench for mux_arb_ctrl_4ch: directed and randomized packet transactions
// checked against a transaction-level round-robin model.
module tb_mux_arb_ctrl_4ch;

  localparam int unsigned TO  = 16;
  localparam int unsigned GAP = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        arb_en;
  logic [3:0]  pkt_rdy;
  logic [3:0]  pkt_eop;
  logic [3:0]  fifo_ren;
  logic        grant_vld;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [15:0] pkt_total_cnt;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_last = 3;
  logic [15:0] exp_cnt = '0;
  int unsigned next_lat = 0;

  always #5 sys_clk = ~sys_clk;

  mux_arb_ctrl_4ch #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .arb_en       (arb_en),
    .pkt_rdy      (pkt_rdy),
    .pkt_eop      (pkt_eop),
    .fifo_ren     (fifo_ren),
    .grant_vld    (grant_vld),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err),
    .pkt_total_cnt(pkt_total_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First ready channel after the last owner, scanning upward with wrap
  function automatic int unsigned model_winner(input logic [3:0] rdy);
    for (int unsigned k = 1; k <= 4; k++) begin
      int unsigned c;
      c = (exp_last + k) % 4;
      if (rdy[c]) return c;
    end
    return 0;
  endfunction

  // One packet transaction, started at a negedge. len = grant cycles before
  // the EOP cycle; timeout mode never raises the owner's EOP.
  task automatic do_packet(input logic [3:0] rdy, input int unsigned len_in,
                           input bit timeout, input bit noisy, input bit preset,
                           input int unsigned lat);
    int unsigned w;
    int unsigned waited;
    int unsigned len;
    logic [3:0]  wmask;
    logic [3:0]  nz;
    w      = model_winner(rdy);
    wmask  = 4'(1 << w);
    nz     = noisy ? ~wmask : 4'b0000;
    len    = timeout ? TO - 1 : len_in;
    pkt_rdy = rdy;
    arb_en  = 1'b1;
    pkt_eop = '0;
    waited  = 0;
    do begin
      @(negedge sys_clk);
      waited++;
    end while (!grant_vld && waited < 40);
    check("grant_vld", {31'd0, grant_vld}, 32'd1);
    if (lat != 0) check("grant_latency", waited, lat);
    check("grant_id", {30'd0, grant_id}, w);
    check("grant_ren", {28'd0, fifo_ren}, {28'd0, wmask});
    if (preset) begin
      force dut.pkt_total_cnt = 16'hFFFF;
      #1;
      release dut.pkt_total_cnt;
      exp_cnt = 16'hFFFF;
    end
    for (int unsigned j = 0; j < len; j++) begin
      pkt_eop = nz;
      pkt_rdy = 4'($urandom);
      arb_en  = 1'($urandom);
      @(negedge sys_clk);
      check("hold_ren", {28'd0, fifo_ren}, {28'd0, wmask});
      check("hold_id", {30'd0, grant_id}, w);
      check("hold_to", {31'd0, timeout_err}, 32'd0);
      check("hold_cnt", {16'd0, pkt_total_cnt}, {16'd0, exp_cnt});
    end
    pkt_eop = timeout ? nz : (nz | wmask);
    @(negedge sys_clk);
    pkt_eop = '0;
    pkt_rdy = '0;
    arb_en  = 1'b1;
    exp_last = w;
    if (!timeout) exp_cnt = exp_cnt + 16'd1;
    check("end_vld", {31'd0, grant_vld}, 32'd0);
    check("end_ren", {28'd0, fifo_ren}, 32'd0);
    check("end_to", {31'd0, timeout_err}, {31'd0, timeout});
    check("end_cnt", {16'd0, pkt_total_cnt}, {16'd0, exp_cnt});
    check("end_id_hold", {30'd0, grant_id}, w);
    if (timeout) begin
      @(negedge sys_clk);
      check("to_pulse_drop", {31'd0, timeout_err}, 32'd0);
      next_lat = GAP;
    end else begin
      next_lat = GAP + 1;
    end
  endtask

  initial begin
    int unsigned w;
    sys_rst = 1'b1;
    arb_en  = 1'b0;
    pkt_rdy = '0;
    pkt_eop = '0;
    repeat (2) @(negedge sys_clk);
    check("rst_vld", {31'd0, grant_vld}, 32'd0);
    check("rst_ren", {28'd0, fifo_ren}, 32'd0);
    check("rst_id", {30'd0, grant_id}, 32'd0);
    check("rst_to", {31'd0, timeout_err}, 32'd0);
    check("rst_cnt", {16'd0, pkt_total_cnt}, 32'd0);

    // All channels ready: rotation 0,1,2,3,0; first grant two edges after release
    sys_rst = 1'b0;
    do_packet(4'hF, 10, 1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 4; i++) do_packet(4'hF, 10, 1'b0, 1'b0, 1'b0, next_lat);
    check("rotation_cnt", {16'd0, pkt_total_cnt}, 32'd5);

    // Single channel 2
    do_packet(4'b0100, 4, 1'b0, 1'b0, 1'b0, next_lat);
    // Channel 1 times out, then search resumes at channel 2
    do_packet(4'b0010, 0, 1'b1, 1'b0, 1'b0, next_lat);
    do_packet(4'hF, 2, 1'b0, 1'b0, 1'b0, next_lat);
    // Foreign EOPs while channel 0 owns the output
    do_packet(4'b0001, 6, 1'b0, 1'b1, 1'b0, next_lat);

    // arb_en low blocks new grants
    pkt_rdy = 4'hF;
    arb_en  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      check("arb_en_block", {31'd0, grant_vld}, 32'd0);
    end
    do_packet(4'hF, 3, 1'b0, 1'b0, 1'b0, 1);

    // EOP in the timeout cycle completes normally
    do_packet(4'($urandom_range(1, 15)), TO - 1, 1'b0, 1'b1, 1'b0, next_lat);
    // Counter wrap
    do_packet(4'hF, 3, 1'b0, 1'b0, 1'b1, next_lat);
    check("cnt_wrap", {16'd0, pkt_total_cnt}, 32'd0);

    // Asynchronous reset in the middle of a grant
    pkt_rdy = 4'b0001;
    arb_en  = 1'b1;
    w = 0;
    do begin
      @(negedge sys_clk);
      w++;
    end while (!grant_vld && w < 40);
    check("pre_rst_grant", {31'd0, grant_vld}, 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("arst_vld", {31'd0, grant_vld}, 32'd0);
    check("arst_ren", {28'd0, fifo_ren}, 32'd0);
    check("arst_id", {30'd0, grant_id}, 32'd0);
    check("arst_cnt", {16'd0, pkt_total_cnt}, 32'd0);
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    exp_last = 3;
    exp_cnt  = '0;
    do_packet(4'b1000, 2, 1'b0, 1'b0, 1'b0, 2);

    // Randomized transactions
    for (int i = 0; i < 16; i++) begin
      do_packet(4'($urandom_range(1, 15)), $urandom_range(0, TO - 1),
                ($urandom_range(0, 4) == 0), 1'($urandom), 1'b0, next_lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
